// File: rtl/decoder_pkg.sv
// Shared types for the decoder backtrack stack.
//   DEC_DATA_W / DEC_N_W : field widths of one stack entry
//   stack_entry_t        : packed {data, n} entry as held in storage
//   stack_op_e           : per-edge operation chosen by the stack control decode
package decoder_pkg;

  localparam int unsigned DEC_DATA_W = 32;
  localparam int unsigned DEC_N_W    = 16;

  typedef struct packed {
    logic [DEC_DATA_W-1:0] data;
    logic [DEC_N_W-1:0]    n;
  } stack_entry_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_FLUSH
  } stack_op_e;

endpackage

// File: rtl/decoder_backtrack_stack_if.sv
// Request/response bundle between the decoder control FSM (master) and the
// backtrack stack (slave).
//   master drives : push, pop, flush, data_in, n_in, peek_idx, err_clr
//   slave drives  : data_out, n_out, peek_data, peek_n, peek_valid, count,
//                   full, almost_full, empty, overflow, underflow
interface decoder_backtrack_stack_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_WIDTH    = 16,
  parameter int unsigned PTR_W      = 5
);

  logic                  push;
  logic                  pop;
  logic                  flush;
  logic [DATA_WIDTH-1:0] data_in;
  logic [N_WIDTH-1:0]    n_in;
  logic [PTR_W-1:0]      peek_idx;
  logic                  err_clr;

  logic [DATA_WIDTH-1:0] data_out;
  logic [N_WIDTH-1:0]    n_out;
  logic [DATA_WIDTH-1:0] peek_data;
  logic [N_WIDTH-1:0]    peek_n;
  logic                  peek_valid;
  logic [PTR_W-1:0]      count;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, pop, flush, data_in, n_in, peek_idx, err_clr,
    input  data_out, n_out, peek_data, peek_n, peek_valid, count,
           full, almost_full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, flush, data_in, n_in, peek_idx, err_clr,
    output data_out, n_out, peek_data, peek_n, peek_valid, count,
           full, almost_full, empty, overflow, underflow
  );

endinterface

// File: rtl/decoder_stack_mem.sv
// Storage array for the backtrack stack: STACK_DEPTH x stack_entry_t registers.
//   clk        : clock
//   wr_en      : write strobe
//   wr_addr    : write slot
//   wr_entry   : entry written
//   top_addr   : read port 0 address (top of stack)
//   top_entry  : read port 0 data, combinational
//   peek_addr  : read port 1 address (peek)
//   peek_entry : read port 1 data, combinational
// Contents are intentionally not reset; the top module gates reads by count.
module decoder_stack_mem
  import decoder_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned AW          = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  stack_entry_t  wr_entry,
  input  logic [AW-1:0] top_addr,
  output stack_entry_t  top_entry,
  input  logic [AW-1:0] peek_addr,
  output stack_entry_t  peek_entry
);

  stack_entry_t mem_q [STACK_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_entry;
    end
  end

  assign top_entry  = mem_q[top_addr];
  assign peek_entry = mem_q[peek_addr];

endmodule

// File: rtl/decoder_backtrack_stack.sv
// LIFO of decoder backtrack state with replace, flush, random-depth peek,
// occupancy/almost-full and sticky overflow/underflow flags.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : decoder_backtrack_stack_if slave (requests in, top/peek/status out)
module decoder_backtrack_stack
  import decoder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEC_DATA_W,
  parameter int unsigned N_WIDTH        = DEC_N_W,
  parameter int unsigned STACK_DEPTH    = 16,
  parameter int unsigned ALMOST_FULL_TH = 14
) (
  input logic                      clk,
  input logic                      rst,
  decoder_backtrack_stack_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned AW    = $clog2(STACK_DEPTH);

  if (STACK_DEPTH < 2) begin : g_bad_depth
    $error("decoder_backtrack_stack: STACK_DEPTH must be >= 2");
  end
  if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > STACK_DEPTH) begin : g_bad_th
    $error("decoder_backtrack_stack: ALMOST_FULL_TH must be in 1..STACK_DEPTH");
  end
  if (DATA_WIDTH != DEC_DATA_W || N_WIDTH != DEC_N_W) begin : g_bad_width
    $error("decoder_backtrack_stack: field widths must match decoder_pkg");
  end

  logic [PTR_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  stack_op_e        op;
  logic             is_full, is_empty, peek_valid;
  logic             wr_en;
  logic [AW-1:0]    wr_addr, top_addr, peek_addr;
  stack_entry_t     wr_entry, top_entry, peek_entry;

  assign is_full    = (count_q == PTR_W'(STACK_DEPTH));
  assign is_empty   = (count_q == '0);
  assign peek_valid = (bus.peek_idx < count_q);

  // Push+pop on an empty stack degrades to a plain push, so no underflow.
  always_comb begin
    op = OP_NONE;
    if (bus.flush) begin
      op = OP_FLUSH;
    end else if (bus.push && bus.pop) begin
      op = is_empty ? OP_PUSH : OP_REPLACE;
    end else if (bus.push) begin
      op = OP_PUSH;
    end else if (bus.pop) begin
      op = OP_POP;
    end
  end

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q & ~bus.err_clr;
    underflow_d = underflow_q & ~bus.err_clr;
    wr_en       = 1'b0;
    unique case (op)
      OP_FLUSH: count_d = '0;
      OP_REPLACE: wr_en = 1'b1;
      OP_PUSH: begin
        if (is_full) begin
          overflow_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + PTR_W'(1);
        end
      end
      OP_POP: begin
        if (is_empty) begin
          underflow_d = 1'b1;
        end else begin
          count_d = count_q - PTR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Address arithmetic is only meaningful when the result is in range; the
  // outputs are gated by empty/peek_valid so truncated values are harmless.
  assign top_addr  = AW'(count_q - PTR_W'(1));
  assign peek_addr = AW'(count_q - PTR_W'(1) - bus.peek_idx);
  assign wr_addr   = (op == OP_REPLACE) ? top_addr : AW'(count_q);
  assign wr_entry  = '{data: bus.data_in, n: bus.n_in};

  decoder_stack_mem #(
    .STACK_DEPTH(STACK_DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_entry  (wr_entry),
    .top_addr  (top_addr),
    .top_entry (top_entry),
    .peek_addr (peek_addr),
    .peek_entry(peek_entry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.data_out    = is_empty ? '0 : top_entry.data;
  assign bus.n_out       = is_empty ? '0 : top_entry.n;
  assign bus.peek_data   = peek_valid ? peek_entry.data : '0;
  assign bus.peek_n      = peek_valid ? peek_entry.n : '0;
  assign bus.peek_valid  = peek_valid;
  assign bus.count       = count_q;
  assign bus.full        = is_full;
  assign bus.almost_full = (count_q >= PTR_W'(ALMOST_FULL_TH));
  assign bus.empty       = is_empty;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_decoder_backtrack_stack.sv
// Directed bench for decoder_backtrack_stack (default 32/16/16/14 parameters).
module tb_decoder_backtrack_stack;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  decoder_backtrack_stack_if #(.DATA_WIDTH(32), .N_WIDTH(16), .PTR_W(5)) bus ();

  decoder_backtrack_stack #(
    .DATA_WIDTH    (32),
    .N_WIDTH       (16),
    .STACK_DEPTH   (16),
    .ALMOST_FULL_TH(14)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Apply one request for one edge, then return all requests to idle.
  task automatic drive(input logic p, input logic po, input logic f, input logic ec,
                       input logic [31:0] d, input logic [15:0] n);
    bus.push = p; bus.pop = po; bus.flush = f; bus.err_clr = ec;
    bus.data_in = d; bus.n_in = n;
    @(posedge clk);
    #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.err_clr = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    vectors++; if (bus.count !== 5'd0) begin miscompares++;
      $display("FAIL rst_count got %0d want 0", bus.count); end
    vectors++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin
      miscompares++; $display("FAIL rst_flags got e%b f%b af%b want e1 f0 af0",
                              bus.empty, bus.full, bus.almost_full); end
    vectors++; if (bus.data_out !== 32'h0 || bus.n_out !== 16'h0 || bus.peek_valid !== 1'b0)
      begin miscompares++; $display("FAIL rst_out got %h/%h pv%b want 0/0 pv0",
                                    bus.data_out, bus.n_out, bus.peek_valid); end
    vectors++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin miscompares++;
      $display("FAIL rst_err got o%b u%b want o0 u0", bus.overflow, bus.underflow); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 32'h0, 16'h0);
    vectors++; if (bus.underflow !== 1'b1) begin miscompares++;
      $display("FAIL pre_rst_underflow got %b want 1", bus.underflow); end
    drive(1, 0, 0, 0, 32'h1, 16'h1);
    drive(1, 0, 0, 0, 32'h2, 16'h2);
    drive(1, 0, 0, 0, 32'h3, 16'h3);
    vectors++; if (bus.count !== 5'd3) begin miscompares++;
      $display("FAIL pre_rst_count got %0d want 3", bus.count); end
    // Mid-cycle assert: must take effect without a clock edge.
    #2 rst = 1'b1;
    #1;
    vectors++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.data_out !== 32'h0) begin
      miscompares++; $display("FAIL async_rst got c%0d e%b d%h want c0 e1 d0",
                              bus.count, bus.empty, bus.data_out); end
    vectors++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin miscompares++;
      $display("FAIL async_rst_err got o%b u%b want o0 u0", bus.overflow, bus.underflow); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_push_peek;
    drive(1, 0, 0, 0, 32'hA, 16'd5);
    vectors++; if (bus.data_out !== 32'hA || bus.n_out !== 16'd5) begin miscompares++;
      $display("FAIL push1_top got %h/%0d want a/5", bus.data_out, bus.n_out); end
    drive(1, 0, 0, 0, 32'hB, 16'd6);
    drive(1, 0, 0, 0, 32'hC, 16'd7);
    vectors++; if (bus.count !== 5'd3 || bus.data_out !== 32'hC || bus.n_out !== 16'd7) begin
      miscompares++; $display("FAIL push3_top got c%0d %h/%0d want c3 c/7",
                              bus.count, bus.data_out, bus.n_out); end
    bus.peek_idx = 5'd2; #1;
    vectors++; if (bus.peek_data !== 32'hA || bus.peek_n !== 16'd5 || bus.peek_valid !== 1'b1)
      begin miscompares++; $display("FAIL peek2 got %h/%0d v%b want a/5 v1",
                                    bus.peek_data, bus.peek_n, bus.peek_valid); end
    bus.peek_idx = 5'd1; #1;
    vectors++; if (bus.peek_data !== 32'hB || bus.peek_n !== 16'd6) begin miscompares++;
      $display("FAIL peek1 got %h/%0d want b/6", bus.peek_data, bus.peek_n); end
    bus.peek_idx = 5'd3; #1;
    vectors++; if (bus.peek_valid !== 1'b0 || bus.peek_data !== 32'h0 || bus.peek_n !== 16'h0)
      begin miscompares++; $display("FAIL peek3 got v%b %h/%h want v0 0/0",
                                    bus.peek_valid, bus.peek_data, bus.peek_n); end
    bus.peek_idx = 5'd0;
  endtask

  task automatic test_fill_overflow;
    for (int i = 3; i < 16; i++) begin
      drive(1, 0, 0, 0, 32'h100 + 32'(i), 16'(i));
      if (i == 12) begin
        vectors++; if (bus.almost_full !== 1'b0) begin miscompares++;
          $display("FAIL af_at13 got %b want 0", bus.almost_full); end
      end
      if (i == 13) begin
        vectors++; if (bus.almost_full !== 1'b1) begin miscompares++;
          $display("FAIL af_at14 got %b want 1", bus.almost_full); end
      end
    end
    vectors++; if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.data_out !== 32'h10F) begin
      miscompares++; $display("FAIL fill got c%0d f%b d%h want c16 f1 d10f",
                              bus.count, bus.full, bus.data_out); end
    drive(1, 0, 0, 0, 32'h55, 16'd3);
    vectors++; if (bus.overflow !== 1'b1 || bus.count !== 5'd16 || bus.data_out !== 32'h10F)
      begin miscompares++; $display("FAIL ovf_push got o%b c%0d d%h want o1 c16 d10f",
                                    bus.overflow, bus.count, bus.data_out); end
    drive(1, 1, 0, 0, 32'hFF, 16'd9);
    vectors++; if (bus.count !== 5'd16 || bus.data_out !== 32'hFF || bus.n_out !== 16'd9) begin
      miscompares++; $display("FAIL replace_full got c%0d %h/%0d want c16 ff/9",
                              bus.count, bus.data_out, bus.n_out); end
    vectors++; if (bus.overflow !== 1'b1) begin miscompares++;
      $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
    bus.peek_idx = 5'd1; #1;
    vectors++; if (bus.peek_data !== 32'h10E || bus.peek_n !== 16'd14) begin miscompares++;
      $display("FAIL peek_full got %h/%0d want 10e/14", bus.peek_data, bus.peek_n); end
    bus.peek_idx = 5'd0;
    drive(1, 0, 0, 1, 32'h66, 16'd4);
    vectors++; if (bus.overflow !== 1'b1) begin miscompares++;
      $display("FAIL ovf_set_wins got %b want 1", bus.overflow); end
    drive(0, 0, 0, 1, 32'h0, 16'h0);
    vectors++; if (bus.overflow !== 1'b0) begin miscompares++;
      $display("FAIL ovf_clr got %b want 0", bus.overflow); end
  endtask

  task automatic test_underflow;
    drive(0, 1, 0, 0, 32'h0, 16'h0);
    vectors++; if (bus.count !== 5'd15 || bus.data_out !== 32'h10E || bus.full !== 1'b0) begin
      miscompares++; $display("FAIL pop1 got c%0d d%h f%b want c15 d10e f0",
                              bus.count, bus.data_out, bus.full); end
    for (int i = 0; i < 15; i++) drive(0, 1, 0, 0, 32'h0, 16'h0);
    vectors++; if (bus.empty !== 1'b1 || bus.count !== 5'd0 || bus.underflow !== 1'b0) begin
      miscompares++; $display("FAIL drain got e%b c%0d u%b want e1 c0 u0",
                              bus.empty, bus.count, bus.underflow); end
    drive(0, 1, 0, 0, 32'h0, 16'h0);
    vectors++; if (bus.underflow !== 1'b1 || bus.count !== 5'd0) begin miscompares++;
      $display("FAIL udf got u%b c%0d want u1 c0", bus.underflow, bus.count); end
    drive(0, 1, 0, 1, 32'h0, 16'h0);
    vectors++; if (bus.underflow !== 1'b1) begin miscompares++;
      $display("FAIL udf_set_wins got %b want 1", bus.underflow); end
    drive(0, 0, 0, 1, 32'h0, 16'h0);
    vectors++; if (bus.underflow !== 1'b0) begin miscompares++;
      $display("FAIL udf_clr got %b want 0", bus.underflow); end
  endtask

  task automatic test_replace_empty;
    drive(1, 1, 0, 0, 32'h1, 16'd1);
    vectors++; if (bus.count !== 5'd1 || bus.data_out !== 32'h1 || bus.n_out !== 16'd1) begin
      miscompares++; $display("FAIL replace_empty got c%0d %h/%0d want c1 1/1",
                              bus.count, bus.data_out, bus.n_out); end
    vectors++; if (bus.underflow !== 1'b0) begin miscompares++;
      $display("FAIL replace_empty_udf got %b want 0", bus.underflow); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 32'h20 + 32'(i), 16'(i));
    vectors++; if (bus.count !== 5'd5 || bus.data_out !== 32'h23) begin miscompares++;
      $display("FAIL pre_flush got c%0d d%h want c5 d23", bus.count, bus.data_out); end
    drive(1, 0, 1, 0, 32'h99, 16'd8);
    vectors++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.data_out !== 32'h0) begin
      miscompares++; $display("FAIL flush got c%0d e%b d%h want c0 e1 d0",
                              bus.count, bus.empty, bus.data_out); end
    vectors++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin miscompares++;
      $display("FAIL flush_err got o%b u%b want o0 u0", bus.overflow, bus.underflow); end
    drive(1, 0, 0, 0, 32'h7, 16'd2);
    vectors++; if (bus.count !== 5'd1 || bus.data_out !== 32'h7 || bus.n_out !== 16'd2) begin
      miscompares++; $display("FAIL post_flush got c%0d %h/%0d want c1 7/2",
                              bus.count, bus.data_out, bus.n_out); end
  endtask

  task automatic test_back_to_back;
    drive(1, 0, 0, 0, 32'h8, 16'd3);
    drive(0, 1, 0, 0, 32'h0, 16'h0);
    drive(1, 0, 0, 0, 32'h9, 16'd4);
    vectors++; if (bus.count !== 5'd2 || bus.data_out !== 32'h9 || bus.n_out !== 16'd4) begin
      miscompares++; $display("FAIL b2b got c%0d %h/%0d want c2 9/4",
                              bus.count, bus.data_out, bus.n_out); end
    bus.peek_idx = 5'd1; #1;
    vectors++; if (bus.peek_data !== 32'h7 || bus.peek_valid !== 1'b1) begin miscompares++;
      $display("FAIL b2b_peek got %h v%b want 7 v1", bus.peek_data, bus.peek_valid); end
    bus.peek_idx = 5'd0;
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.err_clr = 1'b0;
    bus.data_in = '0; bus.n_in = '0; bus.peek_idx = '0;
    test_reset();
    test_push_peek();
    test_fill_overflow();
    test_underflow();
    test_replace_empty();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
